// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame FSM with 3-sample majority voting,
// LSB-first deserialisation, start-glitch/parity/stop checks and a valid strobe.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [3:0]            bit_cnt,
    input  logic [4:0]            edge_cnt,
    output logic                  cnt_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  cnt_en_q, valid_q, valid_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  s0_q, s1_q, maj_q;
    logic [PRESCALE_W-1:0] edge_w, mid;
    logic                  decide, bit_end;

    assign edge_w  = PRESCALE_W'(edge_cnt);
    assign mid     = prescale >> 1;
    assign decide  = edge_w == mid + PRESCALE_W'(2);
    assign bit_end = edge_w == prescale - PRESCALE_W'(1);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        case (state_q)
            IDLE: if (!rx_in) begin
                state_d   = START;
                par_err_d = 1'b0;
                stp_err_d = 1'b0;
                par_en_d  = par_en;
                par_typ_d = par_typ;
            end
            START: begin
                if (decide && maj_q) state_d = IDLE;
                else if (bit_cnt == 4'd0 && bit_end) state_d = DATA;
            end
            DATA: begin
                if (decide) shift_d = {maj_q, shift_q[DATA_WIDTH-1:1]};
                if (bit_cnt == 4'(DATA_WIDTH) && bit_end) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (decide) par_err_d = maj_q != (^shift_q ^ par_typ_q);
                if (bit_cnt == 4'(DATA_WIDTH + 1) && bit_end) state_d = STOP;
            end
            // The strobe and word are registered here so both are present during DONE.
            STOP: if (decide) begin
                state_d   = DONE;
                stp_err_d = !maj_q;
                valid_d   = maj_q && !par_err_q;
                p_data_d  = valid_d ? shift_q : p_data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_en_q  <= 1'b0;
            shift_q   <= '0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            maj_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_en_q  <= state_d inside {START, DATA, PARITY, STOP};
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            if (edge_w == mid - PRESCALE_W'(1)) s0_q <= rx_in;
            if (edge_w == mid) s1_q <= rx_in;
            if (edge_w == mid + PRESCALE_W'(1)) maj_q <= (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
        end
    end

    assign cnt_en     = cnt_en_q;
    assign p_data     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: drives serial frames through a model of the upstream
// edge/bit counter and checks each frame's outcome against a frame-level model.
module tb_uart_rx_frame_ctrl;
    logic       clk = 1'b0, rst = 1'b1, rx_in = 1'b1, par_en = 1'b0, par_typ = 1'b0;
    logic [7:0] prescale = 8'd8;
    logic [3:0] bit_cnt;
    logic [4:0] edge_cnt;
    logic       cnt_en, data_valid, par_err, stp_err;
    logic [7:0] p_data;
    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0, t_done = -1, vcnt = 0, vcyc = 0, v0;
    logic [7:0] vdata = 8'd0, snap_pd = 8'd0, exp_pd = 8'd0;
    logic       snapped = 1'b0, snap_dv = 1'b0, snap_pe = 1'b0, snap_se = 1'b0;
    logic [7:0] rd;
    logic       rpe, rpt, rpb, rstop;
    int         rgb;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
        .par_typ(par_typ), .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .cnt_en(cnt_en),
        .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    // Upstream edge/bit counter: cleared whenever cnt_en is low.
    always_ff @(posedge clk or posedge rst)
        if (rst || !cnt_en) begin
            bit_cnt  <= 4'd0;
            edge_cnt <= 5'd0;
        end else if (edge_cnt == 5'(prescale - 8'd1)) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else edge_cnt <= edge_cnt + 5'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v);
        rx_in = v;
        @(negedge clk);
        if (data_valid) begin
            vcnt++;
            vcyc  = cyc;
            vdata = p_data;
        end
        if (cyc == t_done) begin
            snapped = 1'b1;
            snap_dv = data_valid;
            snap_pe = par_err;
            snap_se = stp_err;
            snap_pd = p_data;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_bit(input logic v, input int gph);
        for (int j = 0; j < int'(prescale); j++) tick(j == gph ? ~v : v);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbad, input logic stop, input int gbit, input int gap);
        int   mid, f0;
        logic ev, epe, ese;
        mid = int'(prescale) / 2;
        epe = pe & pbad;
        ese = ~stop;
        ev  = ~epe & ~ese;
        if (ev) exp_pd = d;
        par_en  = pe;
        par_typ = pt;
        send_bit(1'b0, -1);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == gbit ? mid + 1 : -1);
        if (pe) send_bit(^d ^ pt ^ pbad, -1);
        f0      = vcnt;
        t_done  = cyc + mid + 4;
        snapped = 1'b0;
        send_bit(stop, -1);
        repeat (gap) tick(1'b1);
        chk("done_seen", 32'(snapped), 32'd1);
        chk("valid_at_done", 32'(snap_dv), 32'(ev));
        chk("par_err", 32'(snap_pe), 32'(epe));
        chk("stp_err", 32'(snap_se), 32'(ese));
        chk("p_data", 32'(snap_pd), 32'(exp_pd));
        chk("strobe_count", 32'(vcnt - f0), 32'(ev));
        if (ev) begin
            chk("strobe_latency", 32'(vcyc), 32'(t_done));
            chk("strobe_data", 32'(vdata), 32'(d));
        end
    endtask

    initial begin
        repeat (3) tick(1'b1);
        chk("rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_p_data", 32'(p_data), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_stp_err", 32'(stp_err), 32'd0);
        rst = 1'b0;
        repeat (3) tick(1'b1);

        prescale = 8'd8;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3);
        prescale = 8'd16;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 3);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 3);

        // Two-cycle start glitch: the sampled start bit reads high, so the frame aborts.
        prescale = 8'd8;
        v0 = vcnt;
        tick(1'b0);
        tick(1'b0);
        chk("glitch_cnt_en_up", 32'(cnt_en), 32'd1);
        repeat (8) tick(1'b1);
        chk("glitch_cnt_en_down", 32'(cnt_en), 32'd0);
        chk("glitch_strobes", 32'(vcnt - v0), 32'd0);
        chk("glitch_par_err", 32'(par_err), 32'd0);
        chk("glitch_stp_err", 32'(stp_err), 32'd0);
        chk("glitch_p_data", 32'(p_data), 32'(exp_pd));

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 3);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3);
        prescale = 8'd16;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3);

        prescale = 8'd8;
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, -1);
        repeat (4) tick(1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_cnt_en", 32'(cnt_en), 32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_p_data", 32'(p_data), 32'd0);
        chk("midrst_par_err", 32'(par_err), 32'd0);
        chk("midrst_stp_err", 32'(stp_err), 32'd0);
        exp_pd = 8'd0;
        repeat (2) tick(1'b1);
        rst = 1'b0;
        repeat (3) tick(1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3);

        prescale = 8'd16;
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3);

        for (int k = 0; k < 40; k++) begin
            prescale = 8'd8 << $urandom_range(0, 2);
            rd    = 8'($urandom);
            rpe   = 1'($urandom);
            rpt   = 1'($urandom);
            rpb   = $urandom_range(0, 3) == 0;
            rstop = $urandom_range(0, 3) != 0;
            rgb   = $urandom_range(0, 11);
            send_frame(rd, rpe, rpt, rpb, rstop, rgb,
                       rstop ? $urandom_range(2, 5) : 2 * int'(prescale) + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller for the UART receive path. It sits directly downstream of the edge/bit counter: it consumes `bit_cnt`/`edge_cnt` and drives that counter's enable. It also performs 3-sample majority sampling of `rx_in`, deserialises LSB-first data, checks the start glitch, parity and stop bit, and emits a parallel word with a one-cycle valid strobe.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..8.
PRESCALE_W, 8, width of the `prescale` input.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
rx_in  input  1  serial line, idle high (already synchronised upstream)
prescale  input  PRESCALE_W  clocks per bit; legal values 8, 16, 32; static during a frame
par_en  input  1  1 = parity bit present after the data bits
par_typ  input  1  0 = even, 1 = odd
bit_cnt  input  4  from the edge/bit counter
edge_cnt  input  5  from the edge/bit counter
cnt_en  output  1  enable to the edge/bit counter; counter clears when low
p_data  output  DATA_WIDTH  last good received word
data_valid  output  1  one-cycle strobe, `p_data` valid
par_err  output  1  parity error for the last frame
stp_err  output  1  stop-bit error for the last frame

Behaviour:
- Reset (async, `rst` = 1): state IDLE. `cnt_en`=0, `p_data`=0, `data_valid`=0, `par_err`=0, `stp_err`=0. The shift register and sampler registers are also cleared. Reset mid-frame aborts the frame with no strobe and no error flag.
- States:
  - IDLE → START when `rx_in`=0.
  - START, DATA, PARITY, STOP: frame in progress.
  - DONE: lasts exactly one cycle, then IDLE.
- `cnt_en` = 1 in START, DATA, PARITY and STOP. It is 0 in IDLE and DONE. It is registered from the state.
- On entry to START:
  - clear `par_err` and `stp_err`;
  - latch `par_en` and `par_typ` for the whole frame; mid-frame changes to the inputs are ignored.
- Sampling:
  - mid = `prescale`/2.
  - `rx_in` is captured at `edge_cnt` = mid-1, mid and mid+1.
  - The majority of the 3 samples is registered at `edge_cnt` = mid+1.
  - The FSM consumes the result at `edge_cnt` = mid+2 (the "decision point").
- START:
  - At the decision point, sample = 1 → glitch: go to IDLE, no flags, no strobe.
  - Otherwise stay in START. Go to DATA when `bit_cnt`=0 and `edge_cnt`=`prescale`-1.
- DATA:
  - At each decision point, shift the sample into the MSB of a right-shifting register, so data is LSB-first.
  - Leave when `bit_cnt`=DATA_WIDTH and `edge_cnt`=`prescale`-1. Go to PARITY if latched `par_en`=1, else STOP.
- PARITY:
  - Expected bit = XOR of the data bits XOR latched `par_typ`.
  - At the decision point, `par_err` <= (sample != expected).
  - Go to STOP when `bit_cnt`=DATA_WIDTH+1 and `edge_cnt`=`prescale`-1.
- STOP:
  - At the decision point, `stp_err` <= (sample == 0).
  - Go to DONE on the same edge. DONE is therefore entered mid-stop-bit, which leaves half a bit of margin for a back-to-back start.
- DONE:
  - If `par_err`=0 and `stp_err`=0: `p_data` <= shift register and `data_valid`=1 for this cycle.
  - Otherwise `p_data` holds its previous value and there is no strobe.
  - Error flags hold until the next START entry.
- Latency: `data_valid` rises 1 cycle after the stop-bit decision point, i.e. `edge_cnt` = mid+3 of the stop bit, in clock terms.
- Back-to-back frames:
  - IDLE samples `rx_in` every cycle. A start bit immediately following the stop bit is accepted.
  - `cnt_en` is low for ≥1 cycle (DONE), which clears the counter before the new frame.
- Line held low:
  - Accepted as a start bit; data = 0.
  - Stop sample 0 → `stp_err`=1, no strobe, then return to IDLE.
  - Because the line is still low, the next frame starts immediately.
- Illegal `prescale` (<8 or odd): behaviour unspecified; not verified.

Test Plan:
- `prescale`=8, `par_en`=0, frame 0xA5 with stop=1 → `data_valid`=1 for one cycle, `p_data`=0xA5, `par_err`=`stp_err`=0.
- `prescale`=16, `par_en`=1, `par_typ`=0, data 0x3C, parity 0 → valid, `p_data`=0x3C. Same frame with parity 1 → `par_err`=1, no strobe, `p_data` stays 0x3C.
- `prescale`=8, `rx_in` low for 2 clocks then high → state returns to IDLE within 1 bit, `cnt_en` drops, no strobe, no flags.
- `prescale`=8, data 0x55, stop bit 0 → `stp_err`=1, no strobe. The next good frame 0x12 clears `stp_err` at START and strobes 0x12.
- `prescale`=16, 1-cycle inverted glitch at `edge_cnt`=8 of data bit 3 of 0xF0 → majority rejects it, `p_data`=0xF0.
- `rst` asserted during data bit 4 of a frame → all outputs 0 immediately. The next full frame 0x81 after release is received correctly. Also run two back-to-back frames 0x01, 0xFE → two strobes with the correct values.
